// File: rtl/pbl_axi_pkg.sv
// Shared AXI4 constants and the burst-master FSM state type.
package pbl_axi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAw,
      StW,
      StB,
      StAr,
      StR,
      StFin
   } burst_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Number of 8-byte beats in one 4 KB page.
   localparam int unsigned AXI_4K_BEATS = 512;

   // Response codes are ordered by severity, so the worst is the numeric max.
   function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 burst initiator: each command becomes one INCR write or read burst, with
// write data streamed in and read data streamed out without added latency.
module axi_burst_master
   import pbl_axi_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64
) (
   input  logic                  a_clk,
   input  logic                  a_rst,

   // Command interface
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [7:0]            cmd_len,

   // Write-data stream
   input  logic                  wd_valid,
   output logic                  wd_ready,
   input  logic [DATA_W-1:0]     wd_data,

   // Read-data stream
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_last,

   // Completion
   output logic                  done,
   output logic [1:0]            resp,
   output logic                  busy,

   // AXI AW channel
   output logic [ADDR_W-1:0]     a_awaddr,
   output logic                  a_awvalid,
   input  logic                  a_awready,
   output logic [7:0]            a_awlen,
   output logic [2:0]            a_awsize,
   output logic [1:0]            a_awburst,

   // AXI W channel
   output logic                  a_wvalid,
   input  logic                  a_wready,
   output logic                  a_wlast,
   output logic [DATA_W-1:0]     a_wdata,
   output logic [DATA_W/8-1:0]   a_wstrb,

   // AXI B channel
   input  logic                  a_bvalid,
   output logic                  a_bready,
   input  logic [1:0]            a_bresp,

   // AXI AR channel
   output logic                  a_arvalid,
   input  logic                  a_arready,
   output logic [ADDR_W-1:0]     a_araddr,
   output logic [2:0]            a_arsize,
   output logic [1:0]            a_arburst,
   output logic [7:0]            a_arlen,

   // AXI R channel
   input  logic                  a_rvalid,
   output logic                  a_rready,
   input  logic                  a_rlast,
   input  logic [DATA_W-1:0]     a_rdata,
   input  logic [1:0]            a_rresp
);

   localparam logic [ADDR_W-1:0] AddrMask = ~(ADDR_W'(7));

   burst_state_e      state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        len_q;
   logic [7:0]        cnt_q;
   logic [1:0]        resp_q;

   logic [9:0]        beat_end;
   logic              crosses_4k;
   logic              w_hs;
   logic              r_hs;
   logic              at_len;
   logic [1:0]        r_status;

   // Last beat index within the page; beyond 511 the burst would cross 4 KB.
   assign beat_end   = {1'b0, cmd_addr[11:3]} + {2'b00, cmd_len};
   assign crosses_4k = beat_end > 10'(AXI_4K_BEATS - 1);

   assign at_len = (cnt_q == len_q);
   assign w_hs   = (state_q == StW) && wd_valid && a_wready;
   assign r_hs   = (state_q == StR) && a_rvalid && rd_ready;

   // Running read status: worst rresp so far, escalated if rlast and the count disagree.
   always_comb begin
      r_status = resp_worst(resp_q, a_rresp);
      if (a_rlast != at_len) begin
         r_status = resp_worst(r_status, AXI_RESP_SLVERR);
      end
   end

   // Burst sequencing FSM with command latches, beat counter and status capture.
   always_ff @(posedge a_clk) begin
      if (a_rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         resp_q  <= AXI_RESP_OKAY;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  addr_q <= cmd_addr & AddrMask;
                  len_q  <= cmd_len;
                  cnt_q  <= '0;
                  if (crosses_4k) begin
                     resp_q  <= AXI_RESP_SLVERR;
                     state_q <= StFin;
                  end else begin
                     resp_q  <= AXI_RESP_OKAY;
                     state_q <= cmd_write ? StAw : StAr;
                  end
               end
            end
            StAw: begin
               if (a_awready) state_q <= StW;
            end
            StW: begin
               if (w_hs) begin
                  if (at_len) begin
                     cnt_q   <= '0;
                     state_q <= StB;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
            StB: begin
               if (a_bvalid) begin
                  resp_q  <= a_bresp;
                  state_q <= StFin;
               end
            end
            StAr: begin
               if (a_arready) state_q <= StR;
            end
            StR: begin
               if (r_hs) begin
                  resp_q <= r_status;
                  if (a_rlast || at_len) begin
                     cnt_q   <= '0;
                     state_q <= StFin;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
            StFin: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Command side and completion status, decoded from the state register.
   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StFin);
   assign resp      = (state_q == StFin) ? resp_q : AXI_RESP_OKAY;

   // Address channels hold the latched fields for the whole handshake.
   assign a_awvalid = (state_q == StAw);
   assign a_awaddr  = addr_q;
   assign a_awlen   = len_q;
   assign a_awsize  = AXI_SIZE_8B;
   assign a_awburst = AXI_BURST_INCR;

   assign a_arvalid = (state_q == StAr);
   assign a_araddr  = addr_q;
   assign a_arlen   = len_q;
   assign a_arsize  = AXI_SIZE_8B;
   assign a_arburst = AXI_BURST_INCR;

   // Write data passes straight through; outside W nothing is accepted.
   assign a_wvalid = (state_q == StW) && wd_valid;
   assign wd_ready = (state_q == StW) && a_wready;
   assign a_wdata  = wd_data;
   assign a_wstrb  = '1;
   assign a_wlast  = (state_q == StW) && at_len;

   assign a_bready = (state_q == StB);

   // Read data passes straight through to the output stream.
   assign rd_valid = (state_q == StR) && a_rvalid;
   assign a_rready = (state_q == StR) && rd_ready;
   assign rd_data  = a_rdata;
   assign rd_last  = (state_q == StR) && a_rlast;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed, table-driven bench for axi_burst_master with a small in-bench AXI slave.
module tb_axi_burst_master;
   import pbl_axi_pkg::*;

   logic        a_clk;
   logic        a_rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic        wd_valid, wd_ready;
   logic [63:0] wd_data;
   logic        rd_valid, rd_ready, rd_last;
   logic [63:0] rd_data;
   logic        done, busy;
   logic [1:0]  resp;
   logic [31:0] a_awaddr, a_araddr;
   logic        a_awvalid, a_awready, a_arvalid, a_arready;
   logic [7:0]  a_awlen, a_arlen;
   logic [2:0]  a_awsize, a_arsize;
   logic [1:0]  a_awburst, a_arburst;
   logic        a_wvalid, a_wready, a_wlast;
   logic [63:0] a_wdata;
   logic [7:0]  a_wstrb;
   logic        a_bvalid, a_bready;
   logic [1:0]  a_bresp;
   logic        a_rvalid, a_rready, a_rlast;
   logic [63:0] a_rdata;
   logic [1:0]  a_rresp;

   int n_checks = 0;
   int n_fail   = 0;

   axi_burst_master #(.ADDR_W(32), .DATA_W(64)) dut (
      .a_clk(a_clk), .a_rst(a_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .done(done), .resp(resp), .busy(busy),
      .a_awaddr(a_awaddr), .a_awvalid(a_awvalid), .a_awready(a_awready),
      .a_awlen(a_awlen), .a_awsize(a_awsize), .a_awburst(a_awburst),
      .a_wvalid(a_wvalid), .a_wready(a_wready), .a_wlast(a_wlast),
      .a_wdata(a_wdata), .a_wstrb(a_wstrb),
      .a_bvalid(a_bvalid), .a_bready(a_bready), .a_bresp(a_bresp),
      .a_arvalid(a_arvalid), .a_arready(a_arready), .a_araddr(a_araddr),
      .a_arsize(a_arsize), .a_arburst(a_arburst), .a_arlen(a_arlen),
      .a_rvalid(a_rvalid), .a_rready(a_rready), .a_rlast(a_rlast),
      .a_rdata(a_rdata), .a_rresp(a_rresp)
   );

   initial a_clk = 1'b0;
   always #5 a_clk = ~a_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [31:0] exp_addr;
      bit          stall;
      int          err_beat;    // slave beat index returning SLVERR, -1 none
      int          rlast_beat;  // slave beat index carrying rlast, -1 none
      logic [1:0]  bresp;
      bit          exp_rej;
      logic [1:0]  exp_resp;
      int          exp_beats;
      int          exp_lat;     // cycles from command handshake to done, 0 = unchecked
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge a_clk);
      #1;
   endtask

   task automatic run_cmd(input vec_t v);
      int  cyc;
      int  beats;
      int  guard;
      int  s;
      bit  fin;
      bit  rv;
      logic [63:0] exp_data;
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_len   = v.len;
      #1;
      check("cmd_ready_idle", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      cyc = 1;
      #1;
      if (v.exp_rej) begin
         check("reject_no_addr_valid", {a_awvalid, a_arvalid}, 0);
      end else if (v.wr) begin
         check("awvalid", a_awvalid, 1);
         check("awaddr", a_awaddr, v.exp_addr);
         check("awlen", a_awlen, v.len);
         a_awready = 1'b1;
         tick();
         cyc++;
         a_awready = 1'b0;
         beats = 0;
         guard = 0;
         while (beats <= int'(v.len) && guard < 200) begin
            exp_data = 64'hA5A5_0000_0000_0000 | 64'(beats + 1);
            wd_valid = 1'b1;
            wd_data  = exp_data;
            a_wready = v.stall ? ((guard % 3) != 0) : 1'b1;
            #1;
            if (a_wvalid && a_wready) begin
               check("wdata", a_wdata, exp_data);
               check("wlast", a_wlast, beats == int'(v.len));
               beats++;
            end
            tick();
            cyc++;
            guard++;
         end
         wd_valid = 1'b0;
         a_wready = 1'b0;
         if (guard >= 200) check("w_beats_timeout", beats, v.len + 1);
         a_bvalid = 1'b1;
         a_bresp  = v.bresp;
         #1;
         check("bready", a_bready, 1);
         tick();
         cyc++;
         a_bvalid = 1'b0;
         a_bresp  = 2'b00;
      end else begin
         check("arvalid", a_arvalid, 1);
         check("araddr", a_araddr, v.exp_addr);
         check("arlen", a_arlen, v.len);
         a_arready = 1'b1;
         tick();
         cyc++;
         a_arready = 1'b0;
         s = 0;
         rv = 1'b0;
         fin = 1'b0;
         guard = 0;
         while (!fin && guard < 200) begin
            if (!rv) rv = v.stall ? ((guard % 3) != 1) : 1'b1;
            a_rvalid = rv;
            a_rdata  = 64'h5A5A_0000_0000_0000 | 64'(s);
            a_rlast  = (s == v.rlast_beat);
            a_rresp  = (s == v.err_beat) ? 2'b10 : 2'b00;
            rd_ready = v.stall ? ((guard % 4) != 2) : 1'b1;
            #1;
            if (rd_valid && rd_ready) begin
               exp_data = 64'h5A5A_0000_0000_0000 | 64'(s);
               check("rd_data", rd_data, exp_data);
               check("rd_last", rd_last, s == v.rlast_beat);
               if (s == v.rlast_beat || s == int'(v.len)) fin = 1'b1;
               s++;
               rv = 1'b0;
            end
            tick();
            cyc++;
            guard++;
         end
         a_rvalid = 1'b0;
         a_rlast  = 1'b0;
         a_rresp  = 2'b00;
         rd_ready = 1'b0;
         check("r_beats", s, v.exp_beats);
      end
      #1;
      check("done", done, 1);
      check("resp", resp, v.exp_resp);
      check("cmd_ready_fin", cmd_ready, 0);
      if (v.exp_lat != 0) check("latency", cyc, v.exp_lat);
      tick();
      check("done_one_cycle", done, 0);
      check("busy_after", busy, 0);
   endtask

   initial begin
      // wr addr len exp_addr stall err rlast bresp rej resp beats lat
      vecs[0] = '{1'b1, 32'h0000_0000, 8'd3, 32'h0000_0000, 1'b0, -1, -1, 2'b00, 1'b0, 2'b00, 4, 7};
      vecs[1] = '{1'b0, 32'h0000_0040, 8'd7, 32'h0000_0040, 1'b1, -1,  7, 2'b00, 1'b0, 2'b00, 8, 0};
      vecs[2] = '{1'b1, 32'h0000_0FF8, 8'd1, 32'h0000_0000, 1'b0, -1, -1, 2'b00, 1'b1, 2'b10, 0, 1};
      vecs[3] = '{1'b0, 32'h0000_0100, 8'd3, 32'h0000_0100, 1'b0,  1,  3, 2'b00, 1'b0, 2'b10, 4, 6};
      vecs[4] = '{1'b0, 32'h0000_0200, 8'd3, 32'h0000_0200, 1'b0, -1,  1, 2'b00, 1'b0, 2'b10, 2, 4};
      vecs[5] = '{1'b1, 32'h0000_1008, 8'd2, 32'h0000_1008, 1'b1, -1, -1, 2'b01, 1'b0, 2'b01, 3, 0};
      vecs[6] = '{1'b0, 32'h0000_0FF8, 8'd0, 32'h0000_0FF8, 1'b0, -1,  0, 2'b00, 1'b0, 2'b00, 1, 3};
      vecs[7] = '{1'b0, 32'h0000_0FF0, 8'd2, 32'h0000_0000, 1'b0, -1, -1, 2'b00, 1'b1, 2'b10, 0, 1};
      vecs[8] = '{1'b1, 32'h0000_1237, 8'd0, 32'h0000_1230, 1'b0, -1, -1, 2'b00, 1'b0, 2'b00, 1, 4};

      a_rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
      a_awready = 1'b0; a_wready = 1'b0; a_bvalid = 1'b0; a_bresp = 2'b00;
      a_arready = 1'b0; a_rvalid = 1'b0; a_rlast = 1'b0; a_rdata = '0; a_rresp = 2'b00;
      repeat (3) tick();

      check("rst_valids", {a_awvalid, a_arvalid, a_wvalid, a_bready, a_rready, rd_valid,
                           wd_ready, done}, 0);
      check("rst_busy", busy, 0);
      check("rst_resp", resp, 0);
      check("rst_awaddr", a_awaddr, 0);
      check("rst_araddr", a_araddr, 0);
      check("rst_lens", {a_awlen, a_arlen}, 0);
      check("rst_sizes", {a_awsize, a_arsize}, 6'b011_011);
      check("rst_bursts", {a_awburst, a_arburst}, 4'b01_01);
      check("rst_wstrb", a_wstrb, 8'hFF);

      a_rst = 1'b0;
      tick();
      // Write data offered while idle must not be taken.
      wd_valid = 1'b1;
      a_wready = 1'b1;
      #1;
      check("idle_wd_ready", wd_ready, 0);
      check("idle_wvalid", a_wvalid, 0);
      wd_valid = 1'b0;
      a_wready = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) begin
         run_cmd(vecs[i]);
      end

      // Reset in the middle of a 16-beat write.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0800; cmd_len = 8'd15;
      tick();
      cmd_valid = 1'b0;
      a_awready = 1'b1;
      tick();
      a_awready = 1'b0;
      wd_valid = 1'b1;
      a_wready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         wd_data = 64'(b);
         tick();
      end
      #1;
      check("mid_w_wd_ready", wd_ready, 1);
      check("mid_w_busy", busy, 1);
      a_rst = 1'b1;
      tick();
      check("mrst_valids", {a_awvalid, a_arvalid, a_wvalid, a_bready, a_rready, rd_valid,
                            wd_ready, done}, 0);
      check("mrst_busy", busy, 0);
      check("mrst_awaddr", a_awaddr, 0);
      check("mrst_awlen", a_awlen, 0);
      a_rst = 1'b0;
      wd_valid = 1'b0;
      a_wready = 1'b0;
      tick();
      run_cmd(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
